// File: rtl/game_pkg.sv
// Shared screen codes and score arithmetic for the game-flow controller,
// the screen mux and the score display.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LEVEL_INTRO = 3'd1,
    PLAY        = 3'd2,
    PAUSE       = 3'd3,
    LEVEL_CLEAR = 3'd4,
    GAME_OVER   = 3'd5,
    GAME_WIN    = 3'd6
  } screen_t;

  // Clamps a + b to max; callers size max to their own score width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/key_edge.sv
// Registers a level-sensitive key and flags its rising edge, so a held
// key produces exactly one single-cycle action.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic key_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_d <= 1'b0;
    else       key_d <= key;
  end

  assign rise = key & ~key_d;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: screen state, level, score, birds and pigs remaining,
// driven by pixel-collision requests and frame/shot pulses.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter  int NUM_PIGS         = 3,
  parameter  int NUM_BIRDS        = 10,
  parameter  int MAX_LEVEL        = 4,
  parameter  int SCORE_W          = 12,
  parameter  int SCORE_PER_HIT    = 48,
  parameter  int BONUS_PER_BIRD   = 5,
  parameter  int INTRO_FRAMES     = 60,
  parameter  int LAST_SHOT_FRAMES = 90,
  localparam int LEVEL_W          = $clog2(MAX_LEVEL + 1),
  localparam int BIRD_W           = $clog2(NUM_BIRDS + 1),
  localparam int PIG_W            = $clog2(NUM_PIGS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               drawing_request_bird,
  input  logic               drawing_request_pig,
  input  logic               drawing_request_fortress,
  input  logic               drawing_request_boarders,
  input  logic               shoot_bird_pulse,
  input  logic               start_key,
  input  logic               pause_key,
  input  logic               cheat_key,
  output logic [2:0]         screen,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] score,
  output logic [BIRD_W-1:0]  birds_left,
  output logic [PIG_W-1:0]   pigs_left,
  output logic               hit_pulse,
  output logic               new_level_pulse,
  output logic               game_active
);

  localparam int TMR_MAX = (INTRO_FRAMES > LAST_SHOT_FRAMES) ? INTRO_FRAMES : LAST_SHOT_FRAMES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

  screen_t            state, state_n;
  logic [LEVEL_W-1:0] level_n;
  logic [SCORE_W-1:0] score_n;
  logic [BIRD_W-1:0]  birds_n;
  logic [PIG_W-1:0]   pigs_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               hit_flag, hit_flag_n, pig_flag, pig_flag_n;
  logic               hit_pulse_n, new_level_pulse_n;
  logic               start_rise, pause_rise, cheat_rise;
  logic               collide, pig_hit;

  key_edge u_start (.clk(clk), .reset(reset), .key(start_key), .rise(start_rise));
  key_edge u_pause (.clk(clk), .reset(reset), .key(pause_key), .rise(pause_rise));
  key_edge u_cheat (.clk(clk), .reset(reset), .key(cheat_key), .rise(cheat_rise));

  assign collide = drawing_request_bird &
                   (drawing_request_pig | drawing_request_fortress | drawing_request_boarders);
  assign pig_hit = (state == PLAY) & drawing_request_bird & drawing_request_pig & ~pig_flag;

  always_comb begin
    state_n           = state;
    level_n           = level;
    score_n           = score;
    birds_n           = birds_left;
    pigs_n            = pigs_left;
    timer_n           = timer;
    hit_flag_n        = hit_flag;
    pig_flag_n        = pig_flag;
    hit_pulse_n       = 1'b0;
    new_level_pulse_n = 1'b0;

    // Per-frame flags freeze together with everything else while paused.
    if (state != PAUSE) begin
      if (startOfFrame) begin
        hit_flag_n = 1'b0;
        pig_flag_n = 1'b0;
      end
      if (collide && !hit_flag) begin
        hit_pulse_n = 1'b1;
        hit_flag_n  = 1'b1;
      end
    end

    case (state)
      IDLE, GAME_OVER, GAME_WIN: begin
        if (start_rise) begin
          state_n           = LEVEL_INTRO;
          level_n           = '0;
          score_n           = '0;
          birds_n           = BIRD_W'(NUM_BIRDS);
          pigs_n            = PIG_W'(NUM_PIGS);
          timer_n           = '0;
          new_level_pulse_n = 1'b1;
        end
      end
      LEVEL_INTRO: begin
        if (startOfFrame) begin
          if (timer == TMR_W'(INTRO_FRAMES - 1)) begin
            state_n = PLAY;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
      end
      PLAY: begin
        if (pause_rise) begin
          state_n = PAUSE;
        end else if (cheat_rise) begin
          state_n = LEVEL_CLEAR;
          timer_n = '0;
        end else begin
          if (shoot_bird_pulse && birds_left != '0) birds_n = birds_left - 1'b1;
          if (pig_hit) begin
            score_n    = SCORE_W'(sat_add(32'(score), 32'(SCORE_PER_HIT), SCORE_MAX));
            pigs_n     = pigs_left - 1'b1;
            pig_flag_n = 1'b1;
          end
          // Last pig outranks last bird: a clear is checked before the grace window.
          if (pig_hit && pigs_left == PIG_W'(1)) begin
            state_n = LEVEL_CLEAR;
            timer_n = '0;
          end else if (birds_n == '0 && pigs_n != '0) begin
            if (pig_hit) begin
              timer_n = '0;
            end else if (startOfFrame) begin
              if (timer == TMR_W'(LAST_SHOT_FRAMES - 1)) begin
                state_n = GAME_OVER;
                timer_n = '0;
              end else begin
                timer_n = timer + 1'b1;
              end
            end
          end else begin
            timer_n = '0;
          end
        end
      end
      PAUSE: begin
        if (pause_rise) state_n = PLAY;
      end
      LEVEL_CLEAR: begin
        if (birds_left == '0) begin
          if (level == LEVEL_W'(MAX_LEVEL)) begin
            state_n = GAME_WIN;
          end else begin
            state_n           = LEVEL_INTRO;
            level_n           = level + 1'b1;
            birds_n           = BIRD_W'(NUM_BIRDS);
            pigs_n            = PIG_W'(NUM_PIGS);
            timer_n           = '0;
            new_level_pulse_n = 1'b1;
          end
        end else if (startOfFrame) begin
          birds_n = birds_left - 1'b1;
          score_n = SCORE_W'(sat_add(32'(score), 32'(BONUS_PER_BIRD), SCORE_MAX));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      level           <= '0;
      score           <= '0;
      birds_left      <= '0;
      pigs_left       <= '0;
      timer           <= '0;
      hit_flag        <= 1'b0;
      pig_flag        <= 1'b0;
      hit_pulse       <= 1'b0;
      new_level_pulse <= 1'b0;
    end else begin
      state           <= state_n;
      level           <= level_n;
      score           <= score_n;
      birds_left      <= birds_n;
      pigs_left       <= pigs_n;
      timer           <= timer_n;
      hit_flag        <= hit_flag_n;
      pig_flag        <= pig_flag_n;
      hit_pulse       <= hit_pulse_n;
      new_level_pulse <= new_level_pulse_n;
    end
  end

  assign screen      = state;
  assign game_active = (state == PLAY);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios then random actions, each
// checked against an event-level model of the game rules.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int NP   = 3;
  localparam int NB   = 10;
  localparam int ML   = 4;
  localparam int SW   = 8;
  localparam int SPH  = 48;
  localparam int BPB  = 5;
  localparam int INF  = 60;
  localparam int LSF  = 90;
  localparam int SMAX = (1 << SW) - 1;
  localparam int LW   = $clog2(ML + 1);
  localparam int BW   = $clog2(NB + 1);
  localparam int PW   = $clog2(NP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sof = 1'b0, bird = 1'b0, pig = 1'b0, fort = 1'b0, bord = 1'b0, shot = 1'b0;
  logic          start_k = 1'b0, pause_k = 1'b0, cheat_k = 1'b0;
  logic [2:0]    screen;
  logic [LW-1:0] level;
  logic [SW-1:0] score;
  logic [BW-1:0] birds_left;
  logic [PW-1:0] pigs_left;
  logic          hit_pulse, new_level_pulse, game_active;

  game_flow_ctrl #(
    .NUM_PIGS(NP), .NUM_BIRDS(NB), .MAX_LEVEL(ML), .SCORE_W(SW),
    .SCORE_PER_HIT(SPH), .BONUS_PER_BIRD(BPB), .INTRO_FRAMES(INF), .LAST_SHOT_FRAMES(LSF)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .drawing_request_bird(bird), .drawing_request_pig(pig),
    .drawing_request_fortress(fort), .drawing_request_boarders(bord),
    .shoot_bird_pulse(shot), .start_key(start_k), .pause_key(pause_k), .cheat_key(cheat_k),
    .screen(screen), .level(level), .score(score), .birds_left(birds_left),
    .pigs_left(pigs_left), .hit_pulse(hit_pulse), .new_level_pulse(new_level_pulse),
    .game_active(game_active)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int obs_hits = 0, obs_nlp = 0, exp_hits = 0, exp_nlp = 0;

  always @(negedge clk) begin
    if (hit_pulse) obs_hits++;
    if (new_level_pulse) obs_nlp++;
  end

  // Event-level model of the game rules.
  screen_t m_state;
  int m_level, m_score, m_birds, m_pigs, m_intro, m_grace;
  bit m_hitf, m_pigf;

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  function automatic void m_reset();
    m_state = IDLE; m_level = 0; m_score = 0; m_birds = 0; m_pigs = 0;
    m_intro = 0; m_grace = 0; m_hitf = 0; m_pigf = 0;
  endfunction

  function automatic void m_resolve();
    if (m_state == LEVEL_CLEAR && m_birds == 0) begin
      if (m_level == ML) m_state = GAME_WIN;
      else begin
        m_level++; m_birds = NB; m_pigs = NP; m_intro = 0;
        m_state = LEVEL_INTRO; exp_nlp++;
      end
    end
  endfunction

  function automatic void m_frame();
    if (m_state == PAUSE) return;
    m_hitf = 0; m_pigf = 0;
    case (m_state)
      LEVEL_INTRO: begin
        m_intro++;
        if (m_intro == INF) m_state = PLAY;
      end
      PLAY: if (m_birds == 0 && m_pigs > 0) begin
        m_grace++;
        if (m_grace == LSF) m_state = GAME_OVER;
      end
      LEVEL_CLEAR: if (m_birds > 0) begin
        m_birds--; m_score = sat(m_score + BPB);
      end
      default: ;
    endcase
    m_resolve();
  endfunction

  function automatic void m_shot();
    if (m_state == PLAY && m_birds > 0) begin
      m_birds--;
      if (m_birds == 0 && m_pigs > 0) m_grace = 0;
    end
  endfunction

  function automatic void m_collide(input bit p, input bit f, input bit b);
    if (m_state == PAUSE) return;
    if ((p || f || b) && !m_hitf) begin exp_hits++; m_hitf = 1; end
    if (p && m_state == PLAY && !m_pigf) begin
      m_pigf = 1; m_score = sat(m_score + SPH); m_pigs--; m_grace = 0;
      if (m_pigs == 0) begin m_state = LEVEL_CLEAR; m_resolve(); end
    end
  endfunction

  function automatic void m_key(input int k);
    if (k == 0 && (m_state == IDLE || m_state == GAME_OVER || m_state == GAME_WIN)) begin
      m_state = LEVEL_INTRO; m_level = 0; m_score = 0; m_birds = NB; m_pigs = NP;
      m_intro = 0; exp_nlp++;
    end else if (k == 1 && m_state == PLAY) m_state = PAUSE;
    else if (k == 1 && m_state == PAUSE) m_state = PLAY;
    else if (k == 2 && m_state == PLAY) begin m_state = LEVEL_CLEAR; m_resolve(); end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, " screen"}, int'(screen), int'(m_state));
    check({tag, " level"}, int'(level), m_level);
    check({tag, " score"}, int'(score), m_score);
    check({tag, " birds"}, int'(birds_left), m_birds);
    check({tag, " pigs"}, int'(pigs_left), m_pigs);
    check({tag, " active"}, int'(game_active), int'(m_state == PLAY));
    check({tag, " hits"}, obs_hits, exp_hits);
    check({tag, " new_level"}, obs_nlp, exp_nlp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_sof();
    sof = 1'b1; cyc(); sof = 1'b0; cyc(); m_frame();
  endtask

  task automatic do_shot();
    shot = 1'b1; cyc(); shot = 1'b0; cyc(); m_shot();
  endtask

  task automatic do_key(input int k);
    if (k == 0) start_k = 1'b1;
    else if (k == 1) pause_k = 1'b1;
    else cheat_k = 1'b1;
    cyc(); cyc();
    start_k = 1'b0; pause_k = 1'b0; cheat_k = 1'b0;
    cyc();
    m_key(k);
  endtask

  task automatic do_collide(input bit p, input bit f, input bit b, input int n);
    bird = 1'b1; pig = p; fort = f; bord = b;
    repeat (n) cyc();
    bird = 1'b0; pig = 1'b0; fort = 1'b0; bord = 1'b0;
    cyc();
    m_collide(p, f, b);
  endtask

  initial begin
    m_reset();
    repeat (3) cyc();
    check_all("reset");
    reset = 1'b0;
    cyc();

    // 1: start and intro
    do_key(0);
    repeat (INF - 1) do_sof();
    check_all("intro59");
    do_sof();
    check_all("intro60");
    check("t1 screen", int'(screen), int'(PLAY));
    check("t1 nlp", obs_nlp, 1);

    // 2: a long bird/pig overlap inside one frame counts once
    do_collide(1, 0, 0, 200);
    check_all("t2");
    check("t2 score", int'(score), 48);
    check("t2 hits", obs_hits, 1);
    do_sof();

    // 3: clear level 0 with 4 shots, then bonus tally
    repeat (4) do_shot();
    do_collide(1, 0, 0, 3);
    do_sof();
    do_collide(1, 0, 0, 3);
    check_all("t3 clear");
    check("t3 score144", int'(score), 144);
    repeat (6) do_sof();
    check_all("t3 tally");
    check("t3 score174", int'(score), 174);
    check("t3 level", int'(level), 1);

    // 4: out of birds, grace window, game over
    repeat (INF) do_sof();
    repeat (NB) do_shot();
    repeat (LSF - 1) do_sof();
    check_all("t4 grace89");
    do_sof();
    check_all("t4 over");
    check("t4 screen", int'(screen), int'(GAME_OVER));
    do_shot();
    check_all("t4 extra shot");

    // 5: pause freezes everything
    do_key(0);
    repeat (INF) do_sof();
    do_key(1);
    check_all("t5 paused");
    do_shot(); do_shot();
    do_collide(1, 1, 0, 4);
    repeat (200) do_sof();
    do_key(0);
    check_all("t5 frozen");
    do_key(1);
    check_all("t5 resumed");

    // 6: cheat through all levels, score saturates
    for (int lv = 0; lv <= ML; lv++) begin
      if (lv > 0) repeat (INF) do_sof();
      do_collide(1, 0, 0, 2);
      do_sof();
      do_key(2);
      repeat (NB) do_sof();
      check_all("t6 level");
    end
    check("t6 win", int'(screen), int'(GAME_WIN));
    check("t6 sat", int'(score), SMAX);

    // 7: asynchronous reset mid-PLAY
    do_key(0);
    repeat (INF) do_sof();
    check_all("t7 play");
    #2 reset = 1'b1;
    #1 m_reset();
    check("t7 screen", int'(screen), 0);
    check("t7 level", int'(level), 0);
    check("t7 score", int'(score), 0);
    check("t7 birds", int'(birds_left), 0);
    check("t7 pigs", int'(pigs_left), 0);
    check("t7 active", int'(game_active), 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Random actions
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55) do_sof();
      else if (r < 70) do_shot();
      else if (r < 85) do_collide(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                                  bit'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
      else if (r < 92) do_key(0);
      else if (r < 98) do_key(1);
      else do_key(2);
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
